// File: rtl/modal_reg_pkg.sv
// Shared types for the mode-controlled shift register: operation codes,
// sequencer states and the barrel-unit operation select.
package modal_reg_pkg;

   localparam int MODE_W = 4;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD   = 4'd0,
      MODE_SHR    = 4'd1,
      MODE_SHL    = 4'd2,
      MODE_LOAD   = 4'd3,
      MODE_ROR    = 4'd4,
      MODE_ROL    = 4'd5,
      MODE_ASR    = 4'd6,
      MODE_AND    = 4'd7,
      MODE_OR     = 4'd8,
      MODE_XOR    = 4'd9,
      MODE_INC    = 4'd10,
      MODE_DEC    = 4'd11,
      MODE_CAP    = 4'd12,
      MODE_EMIT   = 4'd13,
      MODE_RSVD_E = 4'd14,
      MODE_RSVD_F = 4'd15
   } mode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      EMIT    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      BOP_ROR = 2'd0,
      BOP_ROL = 2'd1,
      BOP_ASR = 2'd2
   } barrel_op_t;

endpackage

// File: rtl/modal_barrel.sv
// Combinational rotate / arithmetic-shift unit used by the single-cycle
// ROR, ROL and ASR modes. Rotates take the amount modulo WIDTH; ASR with
// an amount of WIDTH or more replicates the sign bit across the word.
module modal_barrel
   import modal_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic [SHW-1:0]   shamt_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] res_o
);

   logic [2*WIDTH-1:0] dbl;
   logic [SHW-1:0]     amt_mod;
   logic [31:0]        amt_ext;

   // Rotates work on a doubled copy of the word so the wrapped bits fall out naturally.
   always_comb begin
      amt_ext = 32'(shamt_i);
      amt_mod = SHW'(amt_ext % WIDTH);
      dbl     = '0;
      res_o   = q_i;
      case (op_i)
         BOP_ROR: begin
            dbl   = {q_i, q_i} >> amt_mod;
            res_o = dbl[WIDTH-1:0];
         end
         BOP_ROL: begin
            dbl   = {q_i, q_i} << amt_mod;
            res_o = dbl[2*WIDTH-1:WIDTH];
         end
         BOP_ASR: begin
            if (amt_ext >= 32'(WIDTH)) begin
               res_o = {WIDTH{q_i[WIDTH-1]}};
            end else begin
               res_o = $signed(q_i) >>> shamt_i;
            end
         end
         default: res_o = q_i;
      endcase
   end

endmodule

// File: rtl/modal_shift_reg.sv
// Mode-controlled WIDTH-bit register: single-cycle shift/load/logic/count
// operations in IDLE, plus a counter-driven sequencer that serially
// captures or emits a full word with a busy/done handshake.
module modal_shift_reg
   import modal_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int SHW  = $clog2(WIDTH)
) (
   input  logic              Clk,
   input  logic              nRst,
   input  logic              en,
   input  logic              abort,
   input  logic [MODE_W-1:0] mode,
   input  logic              Ser,
   input  logic [WIDTH-1:0]  D,
   input  logic [SHW-1:0]    shamt,
   output logic [WIDTH-1:0]  Q,
   output logic              Ser_out,
   output logic              carry,
   output logic              busy,
   output logic              done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             done_q, done_d;

   logic [1:0]       bop;
   logic [WIDTH-1:0] barrel_res;
   logic             last_shift;

   // Pick the barrel operation from the mode; only consumed for modes 4-6.
   always_comb begin
      bop = BOP_ROR;
      if (mode == MODE_ROL) begin
         bop = BOP_ROL;
      end else if (mode == MODE_ASR) begin
         bop = BOP_ASR;
      end
   end

   modal_barrel #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_barrel (
      .q_i     (q_q),
      .shamt_i (shamt),
      .op_i    (bop),
      .res_o   (barrel_res)
   );

   assign last_shift = (cnt_q == SHW'(WIDTH - 1));

   // Next-state logic: abort of a running sequence beats enable; everything holds when en=0.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      done_d  = 1'b0;

      if ((state_q != IDLE) && abort) begin
         // Partial contents are kept; the sequence simply ends without a done pulse.
         state_d = IDLE;
         cnt_d   = '0;
      end else if (en) begin
         case (state_q)
            IDLE: begin
               carry_d = 1'b0;
               case (mode)
                  MODE_HOLD: q_d = q_q;
                  MODE_SHR:  q_d = {Ser, q_q[WIDTH-1:1]};
                  MODE_SHL:  q_d = {q_q[WIDTH-2:0], Ser};
                  MODE_LOAD: q_d = D;
                  MODE_ROR,
                  MODE_ROL,
                  MODE_ASR:  q_d = barrel_res;
                  MODE_AND:  q_d = q_q & D;
                  MODE_OR:   q_d = q_q | D;
                  MODE_XOR:  q_d = q_q ^ D;
                  // The extra MSB of the widened sum/difference is exactly the wrap flag.
                  MODE_INC:  {carry_d, q_d} = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
                  MODE_DEC:  {carry_d, q_d} = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
                  MODE_CAP: begin
                     state_d = CAPTURE;
                     cnt_d   = '0;
                  end
                  MODE_EMIT: begin
                     state_d = EMIT;
                     cnt_d   = '0;
                  end
                  default:   q_d = q_q;
               endcase
            end
            CAPTURE, EMIT: begin
               q_d = {(state_q == CAPTURE) ? Ser : 1'b0, q_q[WIDTH-1:1]};
               if (last_shift) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + SHW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset overriding any sequence.
   always_ff @(posedge Clk) begin
      if (!nRst) begin
         state_q <= IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign Q       = q_q;
   assign Ser_out = q_q[0];
   assign carry   = carry_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;

endmodule

// File: tb/tb_modal_shift_reg.sv
// Directed bench for modal_shift_reg (WIDTH=8): a table of single-cycle
// operations followed by hand-written capture/emit/abort/reset sequences.
module tb_modal_shift_reg;
   import modal_reg_pkg::*;

   localparam int W = 8;

   logic         clk;
   logic         nRst;
   logic         en;
   logic         abort;
   logic [3:0]   mode;
   logic         ser;
   logic [W-1:0] d;
   logic [2:0]   shamt;
   logic [W-1:0] q;
   logic         ser_out;
   logic         carry;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;

   modal_shift_reg #(.WIDTH(W)) dut (
      .Clk     (clk),
      .nRst    (nRst),
      .en      (en),
      .abort   (abort),
      .mode    (mode),
      .Ser     (ser),
      .D       (d),
      .shamt   (shamt),
      .Q       (q),
      .Ser_out (ser_out),
      .carry   (carry),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         en;
      logic [3:0]   mode;
      logic [W-1:0] d;
      logic         ser;
      logic [2:0]   shamt;
      logic [W-1:0] exp_q;
      logic         exp_c;
   } vec_t;

   localparam int NV = 27;
   vec_t vecs [NV];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   logic [W-1:0] cap_bits;
   logic [W-1:0] emitted;
   int           busy_cycles;

   initial begin
      // en, mode, d, ser, shamt, expected Q, expected carry
      vecs[0]  = '{1'b1, MODE_LOAD, 8'hA5, 1'b0, 3'd0, 8'hA5, 1'b0};
      vecs[1]  = '{1'b1, MODE_LOAD, 8'h81, 1'b0, 3'd0, 8'h81, 1'b0};
      vecs[2]  = '{1'b1, MODE_ROR,  8'h00, 1'b0, 3'd1, 8'hC0, 1'b0};
      vecs[3]  = '{1'b1, MODE_ROL,  8'h00, 1'b0, 3'd3, 8'h06, 1'b0};
      vecs[4]  = '{1'b1, MODE_LOAD, 8'h90, 1'b0, 3'd0, 8'h90, 1'b0};
      vecs[5]  = '{1'b1, MODE_ASR,  8'h00, 1'b0, 3'd2, 8'hE4, 1'b0};
      vecs[6]  = '{1'b1, MODE_LOAD, 8'h90, 1'b0, 3'd0, 8'h90, 1'b0};
      vecs[7]  = '{1'b1, MODE_ASR,  8'h00, 1'b0, 3'd7, 8'hFF, 1'b0};
      vecs[8]  = '{1'b1, MODE_LOAD, 8'hFE, 1'b0, 3'd0, 8'hFE, 1'b0};
      vecs[9]  = '{1'b1, MODE_INC,  8'h00, 1'b0, 3'd0, 8'hFF, 1'b0};
      vecs[10] = '{1'b1, MODE_INC,  8'h00, 1'b0, 3'd0, 8'h00, 1'b1};
      vecs[11] = '{1'b1, MODE_HOLD, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
      vecs[12] = '{1'b1, MODE_DEC,  8'h00, 1'b0, 3'd0, 8'hFF, 1'b1};
      vecs[13] = '{1'b0, MODE_INC,  8'h00, 1'b0, 3'd0, 8'hFF, 1'b1};
      vecs[14] = '{1'b1, MODE_LOAD, 8'hF0, 1'b0, 3'd0, 8'hF0, 1'b0};
      vecs[15] = '{1'b1, MODE_AND,  8'h3C, 1'b0, 3'd0, 8'h30, 1'b0};
      vecs[16] = '{1'b1, MODE_OR,   8'h05, 1'b0, 3'd0, 8'h35, 1'b0};
      vecs[17] = '{1'b1, MODE_XOR,  8'hFF, 1'b0, 3'd0, 8'hCA, 1'b0};
      vecs[18] = '{1'b1, MODE_SHR,  8'h00, 1'b1, 3'd0, 8'hE5, 1'b0};
      vecs[19] = '{1'b1, MODE_SHL,  8'h00, 1'b0, 3'd0, 8'hCA, 1'b0};
      vecs[20] = '{1'b1, MODE_ROR,  8'h00, 1'b0, 3'd0, 8'hCA, 1'b0};
      vecs[21] = '{1'b1, MODE_ROL,  8'h00, 1'b0, 3'd7, 8'h65, 1'b0};
      vecs[22] = '{1'b1, MODE_ASR,  8'h00, 1'b0, 3'd3, 8'h0C, 1'b0};
      vecs[23] = '{1'b1, MODE_DEC,  8'h00, 1'b0, 3'd0, 8'h0B, 1'b0};
      vecs[24] = '{1'b1, MODE_LOAD, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
      vecs[25] = '{1'b1, MODE_DEC,  8'h00, 1'b0, 3'd0, 8'hFF, 1'b1};
      vecs[26] = '{1'b1, MODE_RSVD_E, 8'h00, 1'b0, 3'd0, 8'hFF, 1'b0};

      // Reset held two cycles while a LOAD of all-ones is presented.
      nRst = 1'b0; en = 1'b1; abort = 1'b0; mode = MODE_LOAD;
      ser = 1'b0; d = 8'hFF; shamt = 3'd0;
      tick();
      tick();
      $display("reset: q=%h carry=%b busy=%b done=%b", q, carry, busy, done);
      check("reset_q", 32'(q), 32'h00);
      check("reset_carry", 32'(carry), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      nRst = 1'b1;

      // Single-cycle operation table.
      for (int i = 0; i < NV; i++) begin
         en = vecs[i].en; mode = vecs[i].mode; d = vecs[i].d;
         ser = vecs[i].ser; shamt = vecs[i].shamt;
         tick();
         $display("vec %0d: mode=%0d en=%b q=%h carry=%b", i, vecs[i].mode, vecs[i].en, q, carry);
         check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
         check($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].exp_c));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
      end

      // Capture of 1,0,1,1,0,0,1,0 with a one-cycle stall after the 3rd bit.
      en = 1'b1; mode = MODE_LOAD; d = 8'h00; tick();
      mode = MODE_CAP; tick();
      $display("cap start: busy=%b q=%h", busy, q);
      check("cap_start_busy", 32'(busy), 32'h1);
      check("cap_start_carry", 32'(carry), 32'h0);
      cap_bits = 8'b0100_1101;
      busy_cycles = 0;
      for (int i = 0; i < W; i++) begin
         mode = MODE_LOAD; d = 8'hFF; ser = cap_bits[i]; en = 1'b1;
         if (busy) busy_cycles++;
         check($sformatf("cap_done_low%0d", i), 32'(done), 32'h0);
         tick();
         if (i == 2) begin
            en = 1'b0; ser = 1'b1;
            if (busy) busy_cycles++;
            tick();
            check("cap_stall_q", 32'(q), 32'hA0);
            en = 1'b1;
         end
      end
      $display("cap end: q=%h busy=%b done=%b busy_cycles=%0d", q, busy, done, busy_cycles);
      check("cap_busy_cycles", 32'(busy_cycles), 32'd9);
      check("cap_q", 32'(q), 32'h4D);
      check("cap_busy_end", 32'(busy), 32'h0);
      check("cap_done", 32'(done), 32'h1);
      mode = MODE_HOLD; tick();
      check("cap_done_pulse", 32'(done), 32'h0);
      check("cap_q_after", 32'(q), 32'h4D);

      // Emit 8'hB4 LSB first.
      mode = MODE_LOAD; d = 8'hB4; tick();
      mode = MODE_EMIT; tick();
      check("emit_start_busy", 32'(busy), 32'h1);
      emitted = '0;
      for (int i = 0; i < W; i++) begin
         mode = MODE_INC;
         emitted[i] = ser_out;
         tick();
      end
      $display("emit end: bits=%h q=%h done=%b", emitted, q, done);
      check("emit_bits", 32'(emitted), 32'hB4);
      check("emit_q", 32'(q), 32'h00);
      check("emit_done", 32'(done), 32'h1);
      check("emit_busy_end", 32'(busy), 32'h0);

      // Start a capture in the same cycle done is high, abort after 3 shifts.
      mode = MODE_CAP; tick();
      check("restart_busy", 32'(busy), 32'h1);
      check("restart_done", 32'(done), 32'h0);
      mode = MODE_HOLD;
      ser = 1'b1; tick();
      ser = 1'b1; tick();
      ser = 1'b0; tick();
      check("abort_pre_q", 32'(q), 32'h60);
      abort = 1'b1; en = 1'b0; tick();
      $display("abort: q=%h busy=%b done=%b", q, busy, done);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_q", 32'(q), 32'h60);
      check("abort_done", 32'(done), 32'h0);
      abort = 1'b0; en = 1'b1; tick();
      check("abort_done_later", 32'(done), 32'h0);
      check("abort_q_later", 32'(q), 32'h60);

      // Abort in IDLE is ignored; the op proceeds.
      abort = 1'b1; mode = MODE_LOAD; d = 8'h3C; tick();
      check("idle_abort_q", 32'(q), 32'h3C);
      abort = 1'b0;

      // Reset in the middle of a capture (cnt=4).
      mode = MODE_CAP; tick();
      mode = MODE_HOLD; ser = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("midcap_q", 32'(q), 32'hF3);
      check("midcap_busy", 32'(busy), 32'h1);
      nRst = 1'b0; tick();
      $display("midcap reset: q=%h busy=%b done=%b", q, busy, done);
      check("midreset_q", 32'(q), 32'h00);
      check("midreset_busy", 32'(busy), 32'h0);
      check("midreset_done", 32'(done), 32'h0);
      nRst = 1'b1;
      mode = MODE_LOAD; d = 8'h77; tick();
      check("post_reset_load", 32'(q), 32'h77);
      check("post_reset_done", 32'(done), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
